// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the serial instruction-memory boot loader.
// Holds the receiver and loader state encodings and the default bit period.
package inst_mem_loader_pkg;

  // 100 MHz system clock, 115200 baud
  localparam int unsigned DefaultClksPerBit = 868;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    L_COUNT,
    L_DATA,
    L_DONE
  } ld_state_e;

endpackage

// File: rtl/inst_mem_loader_uart_rx.sv
// uart_rx_byte: UART 8N1 receiver with a 2-flop input synchronizer.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   byte_valid one-cycle pulse, data holds the received byte
//   frame_err  one-cycle pulse, stop bit sampled low
//   data       last received byte (LSB first on the line)
module uart_rx_byte
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] data
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]      sync_q;
  logic            rx_s;
  rx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;

  assign rx_s = sync_q[1];
  assign data = shreg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 2'b11;
      state_q    <= R_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state_q)
        R_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rx_s) state_q <= R_START;
        end
        R_START: begin
          // Resample at mid start bit to reject glitches
          if (cnt_q == HalfM1) begin
            cnt_q   <= '0;
            state_q <= rx_s ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt_q == FullM1) begin
            cnt_q   <= '0;
            shreg_q <= {rx_s, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= R_STOP;
            else bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt_q == FullM1) begin
            cnt_q      <= '0;
            byte_valid <= rx_s;
            frame_err  <= !rx_s;
            state_q    <= R_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: serial boot loader for the instruction memory.
// First byte is a word count N (1..2^ADDR_W), followed by N little-endian
// 32-bit words written to word addresses 0..N-1. The core stays in reset
// (cpu_hold=1) until the whole image has been written.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   rx               UART 8N1 input
//   we/waddr/wdata   one-cycle instruction-memory write
//   busy             load in progress
//   done             last load completed
//   err              sticky framing / illegal-count error
//   cpu_hold         core reset, 1 = held
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam int unsigned MaxWords = 2 ** ADDR_W;

  logic       byte_valid;
  logic       frame_err;
  logic [7:0] rx_data;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .data      (rx_data)
  );

  ld_state_e         l_state_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic              count_ok;
  logic              last_word;

  assign count_ok  = (rx_data != 8'd0) && (32'(rx_data) <= MaxWords);
  assign last_word = ({1'b0, word_idx_q} == (count_q - (ADDR_W + 1)'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_state_q  <= L_COUNT;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      we <= 1'b0;
      if (frame_err) begin
        // Partial word is dropped; words already written stay in memory
        err       <= 1'b1;
        busy      <= 1'b0;
        done      <= 1'b0;
        cpu_hold  <= 1'b1;
        l_state_q <= L_COUNT;
      end else if (byte_valid) begin
        unique case (l_state_q)
          L_COUNT, L_DONE: begin
            if (count_ok) begin
              count_q    <= (ADDR_W + 1)'(rx_data);
              word_idx_q <= '0;
              byte_idx_q <= '0;
              busy       <= 1'b1;
              err        <= 1'b0;
              done       <= 1'b0;
              cpu_hold   <= 1'b1;
              l_state_q  <= L_DATA;
            end else begin
              err <= 1'b1;
            end
          end
          L_DATA: begin
            byte_idx_q <= byte_idx_q + 1'b1;
            unique case (byte_idx_q)
              2'd0: word_q[7:0]   <= rx_data;
              2'd1: word_q[15:8]  <= rx_data;
              2'd2: word_q[23:16] <= rx_data;
              2'd3: begin
                we    <= 1'b1;
                waddr <= word_idx_q;
                wdata <= {rx_data, word_q};
                if (last_word) l_state_q <= L_DONE;
                else word_idx_q <= word_idx_q + 1'b1;
              end
            endcase
          end
          default: l_state_q <= L_COUNT;
        endcase
      end else if (l_state_q == L_DONE && busy) begin
        // Release the core the cycle after the final write
        busy     <= 1'b0;
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  localparam int unsigned Cpb   = 16;
  localparam int unsigned AddrW = 6;

  logic             clk;
  logic             rst;
  logic             rx;
  logic             we;
  logic [AddrW-1:0] waddr;
  logic [31:0]      wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic             cpu_hold;

  inst_mem_loader #(
    .CLKS_PER_BIT(Cpb),
    .ADDR_W      (AddrW)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .cpu_hold(cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Write-strobe log and receiver pulse counters
  int          we_cnt = 0;
  int          bv_cnt = 0;
  int          fe_cnt = 0;
  logic [31:0] log_addr[16];
  logic [31:0] log_data[16];

  always @(negedge clk) begin
    if (we) begin
      if (we_cnt < 16) begin
        log_addr[we_cnt] = 32'(waddr);
        log_data[we_cnt] = wdata;
      end
      we_cnt = we_cnt + 1;
    end
    if (u_dut.u_rx.byte_valid) bv_cnt = bv_cnt + 1;
    if (u_dut.u_rx.frame_err) fe_cnt = fe_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One 8N1 frame driven on falling edges; a bad stop bit is kept short so the
  // line is high again before the receiver could mistake it for a start bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = stop_ok;
    repeat (stop_ok ? Cpb : 12) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic e_err, input logic e_busy,
                               input logic e_hold, input logic e_done);
    check({tag, ".err"}, 32'(err), 32'(e_err));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(e_hold));
    check({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop_ok;
    logic       e_err;
    logic       e_busy;
    logic       e_hold;
    logic       e_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base;
    int bv0;
    int fe0;
    bit seen;

    vecs[0] = '{b: 8'h00, stop_ok: 1'b1, e_err: 1'b1, e_busy: 1'b0, e_hold: 1'b1, e_done: 1'b0};
    vecs[1] = '{b: 8'h41, stop_ok: 1'b1, e_err: 1'b1, e_busy: 1'b0, e_hold: 1'b1, e_done: 1'b0};
    vecs[2] = '{b: 8'h01, stop_ok: 1'b1, e_err: 1'b0, e_busy: 1'b1, e_hold: 1'b1, e_done: 1'b0};
    vecs[3] = '{b: 8'h55, stop_ok: 1'b0, e_err: 1'b1, e_busy: 1'b0, e_hold: 1'b1, e_done: 1'b0};
    vecs[4] = '{b: 8'h40, stop_ok: 1'b1, e_err: 1'b0, e_busy: 1'b1, e_hold: 1'b1, e_done: 1'b0};
    vecs[5] = '{b: 8'h00, stop_ok: 1'b0, e_err: 1'b1, e_busy: 1'b0, e_hold: 1'b1, e_done: 1'b0};

    rx  = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.we", 32'(we), 32'd0);
    check("reset.waddr", 32'(waddr), 32'd0);
    check("reset.wdata", wdata, 32'd0);
    check_outputs("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Count / error table: illegal counts, framing errors, error clearing
    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].b, vecs[i].stop_ok);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_err, vecs[i].e_busy, vecs[i].e_hold,
                    vecs[i].e_done);
      check($sformatf("vec%0d.we_cnt", i), 32'(we_cnt), 32'd0);
    end
    check("table.frame_errs", 32'(fe_cnt), 32'd2);

    // Two-word load; done/cpu_hold checked the cycle after the final strobe
    base = we_cnt;
    send_byte(8'h02, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h50, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'hB5, 1'b1);
    fork
      send_byte(8'h00, 1'b1);
      begin
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
          @(negedge clk);
          if (we) seen = 1'b1;
        end
        check("load.final_we_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("load.done_next", 32'(done), 32'd1);
        check("load.hold_next", 32'(cpu_hold), 32'd0);
        check("load.we_one_cycle", 32'(we), 32'd0);
      end
    join
    check("load.we_cnt", 32'(we_cnt - base), 32'd2);
    check("load.addr0", log_addr[base], 32'd0);
    check("load.data0", log_data[base], 32'h0050_0013);
    check("load.addr1", log_addr[base+1], 32'd1);
    check("load.data1", log_data[base+1], 32'h00B5_0533);
    check_outputs("load", 1'b0, 1'b0, 1'b0, 1'b1);

    // Glitch shorter than half a bit: no byte, outputs unchanged
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    base = we_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch.byte_valid", 32'(bv_cnt - bv0), 32'd0);
    check("glitch.frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("glitch.we", 32'(we_cnt - base), 32'd0);
    check_outputs("glitch", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reload after completion re-asserts cpu_hold the cycle after byte_valid
    fork
      send_byte(8'h01, 1'b1);
      begin
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
          @(negedge clk);
          if (u_dut.u_rx.byte_valid) seen = 1'b1;
        end
        check("reload.bv_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check_outputs("reload", 1'b0, 1'b1, 1'b1, 1'b0);
      end
    join
    base = we_cnt;
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
    check("reload.we_cnt", 32'(we_cnt - base), 32'd1);
    check("reload.data", log_data[base], 32'h1122_3344);
    check("reload.done", 32'(done), 32'd1);

    // Reset in the middle of a load abandons it
    send_byte(8'h03, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.we", 32'(we), 32'd0);
    check("midrst.waddr", 32'(waddr), 32'd0);
    check("midrst.wdata", wdata, 32'd0);
    check_outputs("midrst", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    base = we_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    check("postrst.we_cnt", 32'(we_cnt - base), 32'd1);
    check("postrst.addr", log_addr[base], 32'd0);
    check("postrst.data", log_data[base], 32'hEFBE_ADDE);
    check_outputs("postrst", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
